// File: rtl/mp_add_seq.sv
// Sequential multi-precision adder: streams LS-word-first operand pairs through a
// 16-bit carry-lookahead core, chaining the carry between beats. Optional macro: MP_ADD_SUB_EN.

module cla_adder #(
  parameter int unsigned DATA_WID = 16
) (
  input  logic [DATA_WID-1:0] a,
  input  logic [DATA_WID-1:0] b,
  input  logic                carry_in,
  output logic [DATA_WID-1:0] sum,
  output logic                carry_out
);
  localparam int unsigned NGRP = DATA_WID / 4;

  logic [DATA_WID-1:0] g, p, c;
  logic [NGRP-1:0]     gg, gp;
  logic [NGRP:0]       gc;

  assign g = a & b;
  assign p = a ^ b;

  // 4-bit lookahead groups; group generate/propagate chain the group carries
  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    gc[0] = carry_in;
    for (int unsigned j = 0; j < NGRP; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
  end

  assign sum       = p ^ c;
  assign carry_out = gc[NGRP];
endmodule

module mp_add_seq #(
  parameter int unsigned DATA_WID  = 16,
  parameter int unsigned MAX_WORDS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_WID-1:0] in_a,
  input  logic [DATA_WID-1:0] in_b,
  input  logic                in_cin,
  input  logic                in_sub,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_WID-1:0] out_sum,
  output logic                out_carry,
  output logic                out_last,
  output logic                out_trunc
);
  localparam int unsigned CW = $clog2(MAX_WORDS);

  typedef enum logic {S_FIRST, S_CONT} state_t;

  state_t              state, state_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic                carry_q;
  logic                xfer, at_max, last, trunc;
  logic                first_cin, cla_cin, cla_cout;
  logic [DATA_WID-1:0] cla_b, cla_sum;

  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;
  assign at_max   = (cnt == CW'(MAX_WORDS - 1));
  assign last     = in_last || at_max;
  assign trunc    = at_max && !in_last;

`ifdef MP_ADD_SUB_EN
  logic sub_q, sub_cur;
  // Mode comes straight from the port on the first beat, from the latch afterwards
  assign sub_cur   = (state == S_FIRST) ? in_sub : sub_q;
  assign cla_b     = sub_cur ? ~in_b : in_b;
  assign first_cin = sub_cur ? 1'b1 : in_cin;
`else
  logic unused_sub;
  assign unused_sub = in_sub;
  assign cla_b      = in_b;
  assign first_cin  = in_cin;
`endif

  assign cla_cin = (state == S_FIRST) ? first_cin : carry_q;

  cla_adder #(.DATA_WID(DATA_WID)) u_cla (
    .a        (in_a),
    .b        (cla_b),
    .carry_in (cla_cin),
    .sum      (cla_sum),
    .carry_out(cla_cout)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (xfer) begin
      if (last) begin
        state_d = S_FIRST;
        cnt_d   = '0;
      end else begin
        state_d = S_CONT;
        cnt_d   = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FIRST;
      cnt       <= '0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_last  <= 1'b0;
      out_trunc <= 1'b0;
`ifdef MP_ADD_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (xfer) begin
        carry_q   <= cla_cout;
        out_valid <= 1'b1;
        out_sum   <= cla_sum;
        out_carry <= cla_cout;
        out_last  <= last;
        out_trunc <= trunc;
`ifdef MP_ADD_SUB_EN
        sub_q     <= sub_cur;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq (MAX_WORDS=4); expectations depend on MP_ADD_SUB_EN.
module tb_mp_add_seq;
  localparam int unsigned W  = 16;
  localparam int unsigned MW = 4;

  typedef logic [W+3:0] exp_t;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, in_cin, in_sub, in_last;
  logic         out_valid, out_ready, out_carry, out_last, out_trunc;
  logic [W-1:0] in_a, in_b, out_sum;
  exp_t         obs, exp_v;
  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  mp_add_seq #(.DATA_WID(W), .MAX_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry(out_carry), .out_last(out_last), .out_trunc(out_trunc)
  );

  assign obs = {out_valid, out_sum, out_carry, out_last, out_trunc};

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic l, input logic t);
    return {1'b1, s, c, l, t};
  endfunction

  task automatic put(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                     input logic sub, input logic last, input exp_t e);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_last = last; in_valid = 1'b1;
    sb.push_back(e);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_last = 1'b0;
    repeat (3) step;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want %h", obs, exp_t'(0)); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    step;
  endtask

  task automatic test_single;
    put(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b1, 1'b0));
    step;
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL single_word: got %h want %h", obs, exp_v); end
    in_valid = 1'b0;
    step;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_multi;
    // in_cin high on the second beat must be ignored
    put(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b0));
    step;
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL multi_w0: got %h want %h", obs, exp_v); end
    put(16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, mk(16'h0002, 1'b0, 1'b1, 1'b0));
    step;
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL multi_w1: got %h want %h", obs, exp_v); end
    put(16'h000A, 16'h0014, 1'b1, 1'b0, 1'b1, mk(16'h001F, 1'b0, 1'b1, 1'b0));
    step;
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL multi_cin: got %h want %h", obs, exp_v); end
    in_valid = 1'b0;
    step;
  endtask

  task automatic test_sub;
`ifdef MP_ADD_SUB_EN
    put(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b1, 1'b0));
`else
    put(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, mk(16'h000C, 1'b0, 1'b1, 1'b0));
`endif
    step;
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL sub_5_7: got %h want %h", obs, exp_v); end
`ifdef MP_ADD_SUB_EN
    put(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1, mk(16'h0002, 1'b1, 1'b1, 1'b0));
`else
    put(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1, mk(16'h000C, 1'b0, 1'b1, 1'b0));
`endif
    step;
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL sub_7_5: got %h want %h", obs, exp_v); end
    // 0001_0000 - 0000_0001, in_sub dropped on beat 2 must not change the mode
`ifdef MP_ADD_SUB_EN
    put(16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, mk(16'hFFFF, 1'b0, 1'b0, 1'b0));
`else
    put(16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, mk(16'h0001, 1'b0, 1'b0, 1'b0));
`endif
    step;
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL sub_multi_w0: got %h want %h", obs, exp_v); end
`ifdef MP_ADD_SUB_EN
    put(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b1, 1'b0));
`else
    put(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, mk(16'h0001, 1'b0, 1'b1, 1'b0));
`endif
    step;
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL sub_multi_w1: got %h want %h", obs, exp_v); end
    in_valid = 1'b0;
    step;
  endtask

  task automatic test_backpressure;
    put(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b0));
    step;
    out_ready = 1'b0;
    put(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      n_cmp++;
      if (obs !== sb[0]) begin n_bad++; $display("FAIL bp_stable[%0d]: got %h want %h", i, obs, sb[0]); end
      step;
    end
    out_ready = 1'b1;
    void'(sb.pop_front());
    step;
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL bp_w1: got %h want %h", obs, exp_v); end
    put(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b1, 1'b0));
    step;
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL bp_w2: got %h want %h", obs, exp_v); end
    in_valid = 1'b0;
    step;
  endtask

  task automatic test_trunc;
    for (int i = 0; i < 4; i++) begin
      put(16'hFFFF, (i == 0) ? 16'h0001 : 16'h0000, 1'b0, 1'b0, 1'b0,
          mk(16'h0000, 1'b1, i == 3, i == 3));
      step;
      exp_v = sb.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_bad++; $display("FAIL trunc_w%0d: got %h want %h", i, obs, exp_v); end
    end
    // a stale carry of 1 would make this 0003
    put(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h0002, 1'b0, 1'b1, 1'b0));
    step;
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL trunc_restart: got %h want %h", obs, exp_v); end
    put(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, mk(16'h0001, 1'b0, 1'b1, 1'b0));
    step;
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL trunc_cin: got %h want %h", obs, exp_v); end
    in_valid = 1'b0;
    step;
  endtask

  task automatic test_reset_mid;
    put(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b0));
    step;
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL rstmid_w0: got %h want %h", obs, exp_v); end
    in_valid = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    n_cmp++;
    if (obs !== '0) begin n_bad++; $display("FAIL rstmid_flush: got %h want %h", obs, exp_t'(0)); end
    put(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h0002, 1'b0, 1'b1, 1'b0));
    step;
    exp_v = sb.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_bad++; $display("FAIL rstmid_fresh: got %h want %h", obs, exp_v); end
    in_valid = 1'b0;
    step;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0]    aw, bw;
    logic            cin0;
    int unsigned     nw;
    longint unsigned pa, pb, s;
    for (int op = 0; op < 20; op++) begin
      nw   = $urandom_range(1, 3);
      cin0 = 1'($urandom_range(0, 1));
      pa = 0; pb = 0;
      for (int unsigned i = 0; i < nw; i++) begin
        aw = W'($urandom);
        bw = W'($urandom);
        pa = pa | (longint'(aw) << (16 * i));
        pb = pb | (longint'(bw) << (16 * i));
        s  = pa + pb + longint'(cin0);
        put(aw, bw, (i == 0) ? cin0 : 1'($urandom_range(0, 1)), 1'b0, i == nw - 1,
            mk(W'(s >> (16 * i)), 1'(s >> (16 * (i + 1))), i == nw - 1, 1'b0));
        step;
        exp_v = sb.pop_front(); n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL b2b_op%0d_w%0d: got %h want %h", op, i, obs, exp_v); end
      end
    end
    in_valid = 1'b0;
    step;
  endtask

  initial begin
    test_reset;
    test_single;
    test_multi;
    test_sub;
    test_backpressure;
    test_trunc;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
